// File: rtl/rom_arbiter_if.sv
// Bundle between the requesters/ROM side (master) and the arbiter (slave).
// The master side drives the client requests and the ROM read data; the slave
// side returns grants, responses and the ROM address.
interface rom_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;

  modport master (
    output req, addr, rom_data,
    input  gnt, rsp_valid, rsp_data, busy, rom_addr
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rsp_valid, rsp_data, busy, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port between N_REQ
// requesters. One read in flight at a time: IDLE -> WAIT -> CAPT -> RESP.
module rom_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a request
  localparam logic [1:0] S_WAIT = 2'd1;  // ROM samples rom_addr this cycle
  localparam logic [1:0] S_CAPT = 2'd2;  // ROM output valid, captured at end
  localparam logic [1:0] S_RESP = 2'd3;  // response pulse to the owner

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  gnt_c;
  logic [N_REQ-1:0]  rsp_valid_c;

  // Pick the first requester at or after the priority pointer, wrapping.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every combinational variable gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant and response pulses; both are suppressed while reset is applied.
  always_comb begin
    gnt_c       = '0;
    rsp_valid_c = '0;
    if (!rst && state_q == S_IDLE && win_found) gnt_c[win_idx] = 1'b1;
    if (!rst && state_q == S_RESP)              rsp_valid_c[owner_q] = 1'b1;
  end

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    rom_addr_d = rom_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_WAIT;
          owner_d    = win_idx;
          rom_addr_d = bus.addr[win_idx*ADDR_W +: ADDR_W];
          ptr_d      = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        rsp_data_d = bus.rom_data;
        state_d    = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; rsp_data clears so it is never X.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      rom_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      rom_addr_q <= rom_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] rom_val(input int a);
    return DW'(a * 17 + 3);
  endfunction

  // Behavioural ROM: registered read, one cycle latency.
  always @(posedge clk) bus.rom_data <= rom_val(int'(bus.rom_addr));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level model: m_cnt counts cycles left in the current read.
  int            m_cnt = 0;
  int            m_ptr = 0;
  int            m_owner = 0;
  logic [AW-1:0] m_rom_addr = '0;
  logic [DW-1:0] m_rsp_data = '0;
  int            m_win;
  logic [N-1:0]  exp_gnt, exp_rsp_valid;
  logic          exp_busy;

  logic [N-1:0]  obs_gnt, obs_rsp_valid;
  logic [DW-1:0] obs_rsp_data;
  logic [AW-1:0] obs_rom_addr;
  logic          obs_busy;

  task automatic model_eval();
    m_win         = -1;
    exp_gnt       = '0;
    exp_rsp_valid = '0;
    if (!rst && m_cnt == 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_win < 0 && bus.req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      end
      if (m_win >= 0) exp_gnt[m_win] = 1'b1;
    end
    if (!rst && m_cnt == 1) exp_rsp_valid[m_owner] = 1'b1;
    exp_busy = (m_cnt != 0);
  endtask

  task automatic model_adv();
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_owner = 0; m_rom_addr = '0; m_rsp_data = '0;
    end else if (m_cnt == 0) begin
      if (m_win >= 0) begin
        m_owner    = m_win;
        m_rom_addr = bus.addr[m_win*AW +: AW];
        m_ptr      = (m_win + 1) % N;
        m_cnt      = 3;
      end
    end else begin
      if (m_cnt == 2) m_rsp_data = rom_val(int'(m_rom_addr));
      m_cnt = m_cnt - 1;
    end
  endtask

  // One clock cycle: sample on the falling edge, compare against the model,
  // then advance the model on the rising edge. Inputs change at posedge+1.
  task automatic run_cycle();
    model_eval();
    @(negedge clk);
    obs_gnt       = bus.gnt;
    obs_rsp_valid = bus.rsp_valid;
    obs_rsp_data  = bus.rsp_data;
    obs_rom_addr  = bus.rom_addr;
    obs_busy      = bus.busy;
    n_checks += 5;
    if (obs_gnt !== exp_gnt) begin
      n_fail++; $display("FAIL cyc %0d model gnt: got %b expected %b", cyc, obs_gnt, exp_gnt);
    end
    if (obs_rsp_valid !== exp_rsp_valid) begin
      n_fail++; $display("FAIL cyc %0d model rsp_valid: got %b expected %b", cyc, obs_rsp_valid, exp_rsp_valid);
    end
    if (obs_busy !== exp_busy) begin
      n_fail++; $display("FAIL cyc %0d model busy: got %b expected %b", cyc, obs_busy, exp_busy);
    end
    if (obs_rom_addr !== m_rom_addr) begin
      n_fail++; $display("FAIL cyc %0d model rom_addr: got %0d expected %0d", cyc, obs_rom_addr, m_rom_addr);
    end
    if (obs_rsp_data !== m_rsp_data) begin
      n_fail++; $display("FAIL cyc %0d model rsp_data: got %0d expected %0d", cyc, obs_rsp_data, m_rsp_data);
    end
    @(posedge clk);
    model_adv();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req  = 2'b11;
    bus.addr = 8'h5A;
    run_cycle();
    run_cycle();
    n_checks += 5;
    if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL reset gnt: got %b expected 00", obs_gnt); end
    if (obs_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset rsp_valid: got %b expected 00", obs_rsp_valid); end
    if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", obs_busy); end
    if (obs_rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset rom_addr: got %0d expected 0", obs_rom_addr); end
    if (obs_rsp_data !== 8'd0) begin n_fail++; $display("FAIL reset rsp_data: got %0d expected 0", obs_rsp_data); end
    rst = 1'b0;
    bus.req = '0;
    run_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.req  = 2'b01;
    bus.addr = {4'd0, 4'd5};
    run_cycle();
    n_checks++;
    if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL single gnt: got %b expected 01", obs_gnt); end
    bus.req  = 2'b00;
    bus.addr = 8'hFF;
    for (int i = 1; i <= 3; i++) begin
      run_cycle();
      n_checks++;
      if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL single busy T+%0d: got %b expected 1", i, obs_busy); end
    end
    n_checks += 2;
    if (obs_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single rsp_valid: got %b expected 01", obs_rsp_valid); end
    if (obs_rsp_data !== 8'd88) begin n_fail++; $display("FAIL single rsp_data: got %0d expected 88", obs_rsp_data); end
    run_cycle();
  endtask

  task automatic test_contention();
    logic [N-1:0]  g_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [DW-1:0] d_exp [4] = '{8'd37, 8'd156, 8'd37, 8'd156};
    do_reset();
    bus.req  = 2'b11;
    bus.addr = {4'd9, 4'd2};
    for (int t = 0; t < 4; t++) begin
      run_cycle();
      n_checks++;
      if (obs_gnt !== g_exp[t]) begin n_fail++; $display("FAIL contention gnt #%0d: got %b expected %b", t, obs_gnt, g_exp[t]); end
      run_cycle();
      run_cycle();
      run_cycle();
      n_checks += 2;
      if (obs_rsp_valid !== g_exp[t]) begin n_fail++; $display("FAIL contention rsp_valid #%0d: got %b expected %b", t, obs_rsp_valid, g_exp[t]); end
      if (obs_rsp_data !== d_exp[t]) begin n_fail++; $display("FAIL contention rsp_data #%0d: got %0d expected %0d", t, obs_rsp_data, d_exp[t]); end
    end
    bus.req = '0;
    run_cycle();
  endtask

  task automatic test_late_arrival();
    do_reset();
    bus.req  = 2'b01;
    bus.addr = {4'd7, 4'd3};
    run_cycle();
    bus.req = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      run_cycle();
      n_checks++;
      if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL late gnt T+%0d: got %b expected 00", i, obs_gnt); end
    end
    run_cycle();
    n_checks++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL late gnt T+4: got %b expected 10", obs_gnt); end
    bus.req = '0;
    for (int i = 0; i < 3; i++) run_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req  = 2'b01;
    bus.addr = {4'd6, 4'd4};
    run_cycle();
    bus.req = 2'b00;
    run_cycle();
    rst = 1'b1;
    run_cycle();
    n_checks++;
    if (obs_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midreset rsp_valid in CAPT: got %b expected 00", obs_rsp_valid); end
    rst = 1'b0;
    bus.req = 2'b10;
    run_cycle();
    n_checks += 4;
    if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", obs_busy); end
    if (obs_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midreset rsp_valid: got %b expected 00", obs_rsp_valid); end
    if (obs_rsp_data !== 8'd0) begin n_fail++; $display("FAIL midreset rsp_data: got %0d expected 0", obs_rsp_data); end
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL midreset gnt: got %b expected 10", obs_gnt); end
    bus.req = 2'b00;
    for (int i = 0; i < 3; i++) run_cycle();
    n_checks += 2;
    if (obs_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL midreset rsp_valid after: got %b expected 10", obs_rsp_valid); end
    if (obs_rsp_data !== 8'd105) begin n_fail++; $display("FAIL midreset rsp_data after: got %0d expected 105", obs_rsp_data); end
  endtask

  task automatic test_addr_sweep();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.req  = 2'b01;
      bus.addr = {4'd0, 4'(k)};
      run_cycle();
      n_checks++;
      if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL sweep gnt addr %0d: got %b expected 01", k, obs_gnt); end
      bus.addr = {4'd0, ~4'(k)};
      run_cycle();
      run_cycle();
      run_cycle();
      n_checks += 2;
      if (obs_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL sweep rsp_valid addr %0d: got %b expected 01", k, obs_rsp_valid); end
      if (obs_rsp_data !== DW'(k * 17 + 3)) begin n_fail++; $display("FAIL sweep rsp_data addr %0d: got %0d expected %0d", k, obs_rsp_data, DW'(k * 17 + 3)); end
    end
    bus.req = '0;
    run_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      bus.req  = N'($urandom);
      bus.addr = (N*AW)'($urandom);
      run_cycle();
    end
    rst = 1'b0;
    bus.req = '0;
    for (int i = 0; i < 5; i++) run_cycle();
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_late_arrival();
    test_reset_mid();
    test_addr_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
